// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared types, ASCII constants and digit helpers for the reporter.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [6:0] cs;
  } snapshot_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam int         MSG_LEN     = 13;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] ascii_tens(input logic [6:0] v);
    logic [6:0] t;
    t = clamp99(v) / 7'd10;
    return ASCII_ZERO + {1'b0, t};
  endfunction

  function automatic logic [7:0] ascii_units(input logic [6:0] v);
    logic [6:0] u;
    u = clamp99(v) % 7'd10;
    return ASCII_ZERO + {1'b0, u};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_byte
// Brief    : 8N1 byte transmitter, LSB first; chains frames without idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import stopwatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       tx,
  output logic       ready,
  output logic       byte_end
);

  localparam int            TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  state_t        r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [2:0]    r_bit_idx, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_tx, w_tx_next;
  logic          w_tick;

  assign w_tick   = (r_state != IDLE) && (r_timer == BIT_LAST);
  assign ready    = (r_state == IDLE);
  assign byte_end = (r_state == STOP) && w_tick;
  assign tx       = r_tx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  // The byte is sampled at the end of the start bit, so the feeder has a
  // whole bit period to present it after requesting a frame.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit_idx;
    w_timer_next = (r_state == IDLE || w_tick) ? '0 : r_timer + TW'(1);
    w_tx_next    = 1'b1;
    case (r_state)
      IDLE: begin
        if (valid) w_state_next = START;
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_shift_next = data;
          w_bit_next   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = {1'b1, r_shift[7:1]};
          w_bit_next   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_tick) w_state_next = valid ? START : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_uart_reporter
// Brief    : Snapshots the stopwatch time and sends "HH:MM:SS.CC\r\n" on UART.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_uart_reporter
  import stopwatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [6:0] milliseconds,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_BYTE = 4'(MSG_LEN - 1);

  snapshot_t  r_snap;
  logic [3:0] r_byte_idx;
  logic       r_busy;
  logic       r_done;
  logic [7:0] w_byte;
  logic       w_ready;
  logic       w_byte_end;
  logic       w_accept;
  logic       w_valid;

  assign w_accept = send && !r_busy && w_ready;
  // While busy, valid only matters at the end of a stop bit: it chains the next frame.
  assign w_valid  = r_busy ? (r_byte_idx != LAST_BYTE) : w_accept;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap     <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_snap     <= {hours, minutes, seconds, milliseconds};
        r_busy     <= 1'b1;
        r_byte_idx <= '0;
      end else if (r_busy && w_byte_end) begin
        if (r_byte_idx == LAST_BYTE) begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_byte_idx <= '0;
        end else begin
          r_byte_idx <= r_byte_idx + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_byte = ASCII_LF;
    case (r_byte_idx)
      4'd0:    w_byte = ascii_tens({1'b0, r_snap.h});
      4'd1:    w_byte = ascii_units({1'b0, r_snap.h});
      4'd2:    w_byte = ASCII_COLON;
      4'd3:    w_byte = ascii_tens({1'b0, r_snap.m});
      4'd4:    w_byte = ascii_units({1'b0, r_snap.m});
      4'd5:    w_byte = ASCII_COLON;
      4'd6:    w_byte = ascii_tens({1'b0, r_snap.s});
      4'd7:    w_byte = ascii_units({1'b0, r_snap.s});
      4'd8:    w_byte = ASCII_DOT;
      4'd9:    w_byte = ascii_tens(r_snap.cs);
      4'd10:   w_byte = ascii_units(r_snap.cs);
      4'd11:   w_byte = ASCII_CR;
      default: w_byte = ASCII_LF;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk      (clk),
    .reset    (reset),
    .data     (w_byte),
    .valid    (w_valid),
    .tx       (tx),
    .ready    (w_ready),
    .byte_end (w_byte_end)
  );

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_uart_reporter
// Brief    : Directed + randomized bench; decodes tx and compares to a text model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_uart_reporter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0;
  logic [5:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [6:0] milliseconds = '0;
  logic       tx;
  logic       busy;
  logic       done;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;

  stopwatch_uart_reporter #(.CLKS_PER_BIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .send         (send),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .milliseconds (milliseconds),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // UART receiver: samples each bit near its middle, 4 clocks per bit.
  logic [7:0] rx_q[$];
  logic [7:0] shreg;
  bit         mon_busy = 1'b0;
  int         mk = 0;
  int         frame_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mk = 0;
      end
    end else begin
      mk++;
      if (mk == 1 && tx !== 1'b0) frame_err++;
      if (mk >= 5 && mk <= 33 && ((mk - 5) % 4) == 0) shreg[(mk - 5) / 4] = tx;
      if (mk == 37) begin
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(shreg);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lim(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic string expect_line(input int h, input int m, input int s, input int c);
    return $sformatf("%02d:%02d:%02d.%02d\r\n", lim(h), lim(m), lim(s), lim(c));
  endfunction

  task automatic check_line(input string tag, input string exp);
    logic [7:0] got;
    check({tag, "_avail"}, 32'(rx_q.size() >= exp.len()), 32'd1);
    for (int i = 0; i < exp.len(); i++) begin
      if (rx_q.size() > 0) got = rx_q.pop_front();
      else got = 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
  endtask

  // One report; with meddle set, seconds change at +50 and a stray send lands at +100.
  task automatic send_report(input int h, input int m, input int s, input int c,
                             input bit meddle, input string tag);
    int a, d, nd;
    @(negedge clk);
    hours = h[5:0]; minutes = m[5:0]; seconds = s[5:0]; milliseconds = c[6:0];
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    a = cyc;
    check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
    check({tag, "_tx_start"}, 32'(tx), 32'd0);
    d = -1;
    nd = 0;
    for (int k = 1; k <= 560; k++) begin
      @(negedge clk);
      if (meddle && k == 50) seconds = 6'd6;
      if (meddle && k == 100) send = 1'b1;
      if (meddle && k == 101) send = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (d < 0) d = cyc;
      end
    end
    check({tag, "_done_latency"}, 32'(d - a), 32'd520);
    check({tag, "_done_count"}, 32'(nd), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_tx_idle_after"}, 32'(tx), 32'd1);
    check_line(tag, expect_line(h, m, s, c));
    check({tag, "_no_extra_bytes"}, 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    int bad, a, d1, d2, nd;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_after_release", 32'(bad), 32'd0);

    send_report(1, 2, 3, 45, 1'b0, "fixed");
    send_report(0, 0, 5, 0, 1'b1, "ignore_busy");
    send_report(63, $urandom_range(0, 63), $urandom_range(0, 63), 127, 1'b0, "clamp");
    repeat (3) send_report($urandom_range(0, 63), $urandom_range(0, 63),
                           $urandom_range(0, 63), $urandom_range(0, 127), 1'b0, "rand");

    // asynchronous reset in the middle of a report
    @(negedge clk);
    hours = 6'd12; minutes = 6'd34; seconds = 6'd56; milliseconds = 7'd78;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (199) @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_abort_tx", 32'(tx), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_hold_tx", 32'(tx), 32'd1);
    reset = 1'b1;
    rx_q.delete();
    repeat (5) @(negedge clk);
    check("post_abort_idle", 32'(busy), 32'd0);
    send_report(23, 59, 58, 99, 1'b0, "post_reset");

    // send held high: back-to-back reports
    @(negedge clk);
    hours = 6'd7; minutes = 6'd8; seconds = 6'd9; milliseconds = 7'd10;
    send = 1'b1;
    @(negedge clk);
    a = cyc;
    d1 = -1;
    d2 = -1;
    nd = 0;
    for (int k = 1; k < 1200; k++) begin
      @(negedge clk);
      if (d1 > 0 && cyc == d1 + 1) begin
        check("b2b_second_start_tx", 32'(tx), 32'd0);
        check("b2b_second_busy", 32'(busy), 32'd1);
      end
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) begin
          d1 = cyc;
          check("b2b_busy_drop", 32'(busy), 32'd0);
        end else if (nd == 2) begin
          d2 = cyc;
        end
      end
    end
    send = 1'b0;
    check("b2b_done_count", 32'(nd), 32'd2);
    check("b2b_first_latency", 32'(d1 - a), 32'd520);
    check("b2b_period", 32'(d2 - d1), 32'd521);
    check_line("b2b_line1", expect_line(7, 8, 9, 10));
    check_line("b2b_line2", expect_line(7, 8, 9, 10));
    bad = 1;
    for (int k = 0; k < 600 && bad != 0; k++) begin
      @(negedge clk);
      if (busy === 1'b0) bad = 0;
    end
    check("b2b_third_finishes", 32'(bad), 32'd0);
    repeat (2) @(negedge clk);
    check_line("b2b_line3", expect_line(7, 8, 9, 10));
    check("frame_errors", 32'(frame_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
